// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the ysyx_24110006 IFU: FSM encoding, reset PC, NOP and AXI response codes.
package ysyx_24110006_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

endpackage

// File: rtl/ysyx_24110006_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, valid/ready handoff to the IDU.
// Optional IFU_ACCESS_FAULT_EN adds o_fault and replaces faulting fetches with a NOP.
module ysyx_24110006_ifu
  import ysyx_24110006_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_arvalid,
  output logic [ADDR_W-1:0] o_araddr,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic [31:0]       i_rdata,
  input  logic [1:0]        i_rresp,
  output logic              o_rready,
  output logic              o_valid,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_pc,
`ifdef IFU_ACCESS_FAULT_EN
  output logic              o_fault,
`endif
  input  logic              i_ready
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [ADDR_W-1:0] target;

  assign target = {i_redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef IFU_ACCESS_FAULT_EN
  logic fault_q, fault_d;
  logic unused_bits;
  assign unused_bits = ^i_redirect_pc[1:0];
  assign o_fault     = fault_q;
`else
  logic unused_bits;
  assign unused_bits = ^{i_redirect_pc[1:0], i_rresp};
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    opc_d     = opc_q;
`ifdef IFU_ACCESS_FAULT_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      StIdle: begin
        state_d = StReq;
        if (i_redirect_valid) pc_d = target;
      end
      StReq: begin
        // AR must stay stable until accepted, so the target waits in next_pc.
        if (i_redirect_valid) begin
          next_pc_d = target;
          kill_d    = 1'b1;
        end
        if (i_arready) state_d = StWait;
      end
      StWait: begin
        if (i_rvalid) begin
          if (kill_q || i_redirect_valid) begin
            pc_d    = i_redirect_valid ? target : next_pc_q;
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d  = i_rdata;
            opc_d   = pc_q;
            state_d = StHold;
`ifdef IFU_ACCESS_FAULT_EN
            fault_d = (i_rresp != RESP_OKAY);
            if (i_rresp != RESP_OKAY) inst_d = NOP_INST;
`endif
          end
        end else if (i_redirect_valid) begin
          next_pc_d = target;
          kill_d    = 1'b1;
        end
      end
      StHold: begin
        // A redirect wins over a same-cycle accept.
        if (i_redirect_valid) begin
          pc_d    = target;
          state_d = StReq;
`ifdef IFU_ACCESS_FAULT_EN
          fault_d = 1'b0;
`endif
        end else if (i_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = StReq;
`ifdef IFU_ACCESS_FAULT_EN
          fault_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      opc_q     <= RESET_PC;
`ifdef IFU_ACCESS_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      opc_q     <= opc_d;
`ifdef IFU_ACCESS_FAULT_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign o_arvalid = (state_q == StReq);
  assign o_rready  = (state_q == StWait);
  assign o_valid   = (state_q == StHold);
  assign o_araddr  = pc_q;
  assign o_inst    = inst_q;
  assign o_pc      = opc_q;

endmodule
